// File: rtl/serial_sub_4bit.sv
// Bit-serial subtractor: computes a - b - b_in one bit per clock, LSB first,
// using a single borrow flip-flop. A start/busy/done handshake sequences it.
module serial_sub_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
    logic             done_q, done_d;

    logic ai, bi, d_bit, br_next;

    assign ai      = a_sh_q[0];
    assign bi      = b_sh_q[0];
    assign d_bit   = ai ^ bi ^ br_q;
    assign br_next = (~ai & bi) | (~(ai ^ bi) & br_q);

    always_comb begin
        // NOTE: every next-state signal gets a hold/default value first so no
        // path through the case below can leave one unassigned (no latches).
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = b_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                br_d     = br_next;
                // New bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0.
                res_sh_d = WIDTH'({d_bit, res_sh_q} >> 1);
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = res_sh_d;
                    b_out_d = br_next;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all registers update
        // together from values sampled before the edge.
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            done_q   <= done_d;
        end
    end

    assign diff  = diff_q;
    assign b_out = b_out_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;

endmodule

// File: doc/serial_sub_4bit.md
# serial_sub_4bit

Bit-serial 4-bit subtractor with borrow-in/borrow-out: the inverse companion to the 4-bit ripple-carry adder. It computes `a - b - b_in` one bit per clock, LSB first, using a single borrow flip-flop in place of a ripple chain. A `start`/`busy`/`done` handshake sequences the operation. The block sits beside the adder in the arithmetic datapath and gives a small-area difference path whose result can be cross-checked against the adder, since `a = diff + b + b_in` mod 32 (where `b_out` is the fifth bit).

## Interface
Parameters:
- `WIDTH`, default 4, operand width; the cycle count of an operation equals `WIDTH`.

Ports:
- `clk`  input  1  single system clock; all logic updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled each rising edge, honoured only in IDLE.
- `a`  input  WIDTH  minuend; captured on the accepted `start` edge.
- `b`  input  WIDTH  subtrahend; captured on the accepted `start` edge.
- `b_in`  input  1  borrow-in; captured on the accepted `start` edge.
- `diff`  output  WIDTH  registered result, `(a - b - b_in) mod 2^WIDTH`.
- `b_out`  output  1  registered borrow-out; 1 when `a < b + b_in` (unsigned).
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse when `diff` and `b_out` update.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: performs the shift sequence.
- Internal registers:
  - `a_sh`, `b_sh`: operand shift registers.
  - `br`: borrow flip-flop.
  - `res_sh`: result shift register.
  - `cnt`: bit counter, 0 to `WIDTH-1`.
- IDLE and `start`=1:
  - Load `a_sh`←`a`, `b_sh`←`b`, `br`←`b_in`, `cnt`←0.
  - Go to RUN and set `busy`←1.
- Each RUN cycle, with `ai`=`a_sh[0]` and `bi`=`b_sh[0]`:
  - Difference bit: `d = ai ^ bi ^ br`.
  - Next borrow: `br ← (~ai & bi) | (~(ai ^ bi) & br)`.
  - Shift `a_sh` and `b_sh` right by 1.
  - Shift `d` into the MSB of `res_sh`, which shifts right.
  - `cnt`←`cnt`+1.
- RUN with `cnt`=`WIDTH-1`:
  - Load `diff` from the completed `res_sh` (including this cycle's bit) and `b_out` from the final borrow.
  - Set `done`←1 and `busy`←0, and return to IDLE.
- `diff` and `b_out` change only on completion and hold their values until the next completion or reset.
- `start` while in RUN is ignored. The operands held in the shift registers are unaffected by changes on the `a`, `b` or `b_in` inputs.
- `done` is high for exactly one cycle per operation and never while `busy`=1.

## Timing
- Reset values: `diff`=0, `b_out`=0, `busy`=0, `done`=0, state=IDLE. All internal registers clear to 0.
- Reset overrides everything, including during RUN. An operation interrupted by reset is abandoned: no `done` pulse follows, and `diff`/`b_out` read 0.
- Latency, with `start` accepted at edge k:
  - `busy`=1 after edge k.
  - Bits are processed at edges k+1 through k+`WIDTH`.
  - After edge k+`WIDTH`: `done`=1, `busy`=0, result valid.
- `done` deasserts after edge k+`WIDTH`+1 unless another completion occurs.
- Throughput:
  - A `start` sampled at edge k+`WIDTH`+1, the first IDLE edge, is accepted. With `start` held high continuously, one result is produced every `WIDTH`+1 cycles.
  - A new `start` accepted while `done`=1 is legal; `done` still drops after one cycle.
- `rst` and `start` high together: reset wins and the start is not accepted.
- Wrap-around: results are modulo 2^`WIDTH`, with the wrap indicated by `b_out`=1. There are no saturation or signed flags.

## Test plan
- Reset: hold `rst` for 2 cycles with `start`=1 -> `diff`=0, `b_out`=0, `busy`=0, `done`=0 throughout; no operation starts.
- `a`=4'b0011, `b`=4'b1001, `b_in`=0, pulse `start` -> `busy` for 4 cycles, then a `done` pulse with `diff`=4'b1010 and `b_out`=1. Cross-check that adder(`diff`, `b`, 0) returns `a` with carry 1.
- `a`=4'b1000, `b`=4'b0110, `b_in`=0 -> `diff`=4'b0010, `b_out`=0, and `done` exactly 4 cycles after the accepting edge.
- Boundary cases:
  - `a`=0, `b`=0, `b_in`=1 -> `diff`=4'b1111, `b_out`=1.
  - `a`=4'b1111, `b`=4'b1111, `b_in`=0 -> `diff`=0, `b_out`=0.
- Hold `start`=1 continuously and change `a`/`b` every cycle -> one `done` every 5 cycles. Each result must match the operands sampled on its accepting edge; `start` during `busy` is ignored.
- Assert `rst` at the 2nd RUN cycle of `a`=4'b0011, `b`=4'b1001 -> no `done`, all outputs 0. A fresh `start` afterwards completes normally with `diff`=4'b1010, `b_out`=1.
